// File: rtl/oven_pkg.sv
// Shared types and constants for the oven plant model and the benches that drive it.
package oven_pkg;

  localparam int TEMP_W = 8;
  localparam int TIME_W = 4;

  // Controller hysteresis interval, exported so benches can derive switching thresholds.
  localparam logic [TEMP_W-1:0] HYST_INTERVAL = 8'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

  function automatic logic [TEMP_W-1:0] sat_add(input logic [TEMP_W-1:0] a,
                                                input logic [TEMP_W-1:0] b);
    logic [TEMP_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[TEMP_W] ? {TEMP_W{1'b1}} : sum[TEMP_W-1:0];
  endfunction

  // Subtract but never go below the floor, including when the raw difference underflows.
  function automatic logic [TEMP_W-1:0] floor_sub(input logic [TEMP_W-1:0] a,
                                                  input logic [TEMP_W-1:0] b,
                                                  input logic [TEMP_W-1:0] floor_val);
    logic [TEMP_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return (diff[TEMP_W] || (diff[TEMP_W-1:0] < floor_val)) ? floor_val : diff[TEMP_W-1:0];
  endfunction

endpackage

// File: rtl/oven_prescaler.sv
// Free-running 0..DIV-1 counter that emits a one-cycle strobe on its last count.
module oven_prescaler #(
  parameter int DIV = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic stb_o
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A clear restarts the period so the next strobe lands a full DIV cycles later.
  always_comb begin
    count_d = count_q + 1'b1;
    if (clr_i || (count_q == LAST)) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign stb_o = (count_q == LAST);

endmodule

// File: rtl/oven_plant_model.sv
// Plant side of the oven loop: discrete thermal model plus a countdown cook timer.
module oven_plant_model
  import oven_pkg::*;
#(
  parameter logic [TEMP_W-1:0] AMBIENT   = 8'd25,
  parameter logic [TEMP_W-1:0] HEAT_STEP = 8'd2,
  parameter logic [TEMP_W-1:0] COOL_STEP = 8'd1,
  parameter int                THERM_DIV = 16,
  parameter int                TICK_DIV  = 100
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              heater_on_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [TIME_W-1:0] set_time_i,
  output logic [TEMP_W-1:0] current_temp_o,
  output logic [TIME_W-1:0] current_time_o,
  output logic              running_o,
  output logic              done_o
);

  logic therm_stb;
  logic tick_stb;
  logic tick_clr;

  logic [TEMP_W-1:0] temp_q, temp_d;
  logic [TIME_W-1:0] time_q, time_d;
  timer_state_e      state_q, state_d;
  logic              running_q, done_q;

  oven_prescaler #(.DIV(THERM_DIV)) u_therm_prescaler (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .stb_o (therm_stb)
  );

  oven_prescaler #(.DIV(TICK_DIV)) u_tick_prescaler (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (tick_clr),
    .stb_o (tick_stb)
  );

  // Thermal model runs regardless of the timer; cooling stops at ambient.
  always_comb begin
    temp_d = temp_q;
    if (therm_stb) begin
      if (heater_on_i) begin
        temp_d = sat_add(temp_q, HEAT_STEP);
      end else if (temp_q > AMBIENT) begin
        temp_d = floor_sub(temp_q, COOL_STEP, AMBIENT);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    tick_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !stop_i && (set_time_i != '0)) begin
          time_d   = set_time_i;
          state_d  = RUN;
          tick_clr = 1'b1;
        end
      end
      RUN: begin
        if (stop_i) begin
          time_d  = '0;
          state_d = IDLE;
        end else if (start_i) begin
          if (set_time_i != '0) begin
            time_d   = set_time_i;
            tick_clr = 1'b1;
          end else begin
            time_d  = '0;
            state_d = IDLE;
          end
        end else if (tick_stb) begin
          if (time_q <= TIME_W'(1)) begin
            time_d  = '0;
            state_d = DONE;
          end else begin
            time_d = time_q - TIME_W'(1);
          end
        end
      end
      DONE: begin
        time_d  = '0;
        state_d = IDLE;
      end
      default: begin
        time_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with current_time.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      temp_q    <= AMBIENT;
      time_q    <= '0;
      state_q   <= IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      temp_q    <= temp_d;
      time_q    <= time_d;
      state_q   <= state_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  assign current_temp_o = temp_q;
  assign current_time_o = time_q;
  assign running_o      = running_q;
  assign done_o         = done_q;

endmodule
